// File: rtl/lsu_datapath_ctrl_pkg.sv
// lsu_datapath_ctrl_pkg: shared size selector encodings, FSM states and size helper.
package lsu_datapath_ctrl_pkg;
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_e;
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return sz == SZ_WORD ? 4'd4 : sz == SZ_HALF ? 4'd2 : 4'd1;
    endfunction
endpackage

// File: rtl/lsu_datapath_ctrl_if.sv
// lsu_datapath_ctrl_if: pipeline request/response bus and word-organised memory port.
interface lsu_req_if #(parameter int XLEN = 32);
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [1:0]      req_size;
    logic            req_signed;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;
    modport master (output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
                    input req_ready, resp_valid, resp_rdata, resp_err);
    modport slave  (input req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
                    output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

interface lsu_mem_if #(parameter int XLEN = 32);
    logic              mem_valid;
    logic              mem_ready;
    logic [XLEN-1:0]   mem_addr;
    logic              mem_we;
    logic [XLEN/8-1:0] mem_be;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;
    modport master (output mem_valid, mem_addr, mem_we, mem_be, mem_wdata,
                    input mem_ready, mem_rdata);
    modport slave  (input mem_valid, mem_addr, mem_we, mem_be, mem_wdata,
                    output mem_ready, mem_rdata);
endinterface

// File: rtl/lsu_datapath_ctrl_lane_align.sv
// lsu_lane_align: byte-lane mask, store data shift and load extract/extend over a two-word window.
module lsu_lane_align
    import lsu_datapath_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]               size_i,
    input  logic                     signed_i,
    input  logic [$clog2(XLEN/8)-1:0] off_i,
    input  logic [XLEN-1:0]          wdata_i,
    input  logic [XLEN-1:0]          rd_lo_i,
    input  logic [XLEN-1:0]          rd_hi_i,
    output logic [2*(XLEN/8)-1:0]    mask_o,
    output logic                     mis_o,
    output logic                     illegal_o,
    output logic [XLEN-1:0]          wd_lo_o,
    output logic [XLEN-1:0]          wd_hi_o,
    output logic [XLEN-1:0]          ld_o
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int IW = $clog2(XLEN);
    logic [3:0]        nbytes;
    logic [2*NB-1:0]   bmask;
    logic [2*XLEN-1:0] sh;
    logic [2*XLEN-1:0] cat;
    logic [XLEN-1:0]   low;
    logic [XLEN-1:0]   lmask;
    logic [IW-1:0]     sidx;
    logic              sbit;
    assign illegal_o = size_i == 2'b11;
    always_comb begin
        nbytes  = size_bytes(size_i);
        bmask   = (2*NB)'((32'd1 << nbytes) - 32'd1);
        mask_o  = bmask << off_i;
        mis_o   = |(off_i & OW'(nbytes - 4'd1));
        sh      = {{XLEN{1'b0}}, wdata_i} << {off_i, 3'b000};
        wd_lo_o = sh[XLEN-1:0];
        wd_hi_o = sh[2*XLEN-1:XLEN];
        cat     = {rd_hi_i, rd_lo_i} >> {off_i, 3'b000};
        low     = cat[XLEN-1:0];
        // a full XLEN=32 word shifts the 1 out, so the mask wraps to all ones and nothing is extended
        lmask   = (XLEN'(1) << {nbytes, 3'b000}) - XLEN'(1);
        sidx    = IW'({nbytes, 3'b000} - 7'd1);
        sbit    = signed_i & low[sidx];
        ld_o    = (low & lmask) | ({XLEN{sbit}} & ~lmask);
    end
endmodule

// File: rtl/lsu_datapath_ctrl.sv
// lsu_datapath_ctrl: load/store unit splitting misaligned accesses into two aligned memory beats.
module lsu_datapath_ctrl
    import lsu_datapath_ctrl_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input logic      clk,
    input logic      rst,
    lsu_req_if.slave req,
    lsu_mem_if.master mem
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    state_e          state_q, state_d;
    logic            write_q, signed_q, err_q;
    logic [1:0]      size_q;
    logic [OW-1:0]   off_q;
    logic [XLEN-1:0] base_q, wdata_q, rd_lo_q, rd_hi_q;
    logic [2*NB-1:0] mask;
    logic            mis, illegal, bad, b1, b2, idle;
    logic [XLEN-1:0] wd_lo, wd_hi, ld;
    assign idle = state_q == IDLE;
    assign b1   = state_q == BEAT1;
    assign b2   = state_q == BEAT2;
    // in IDLE the aligner looks at the incoming request so the error decision needs no extra cycle
    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .size_i    (idle ? req.req_size : size_q),
        .signed_i  (signed_q),
        .off_i     (idle ? req.req_addr[OW-1:0] : off_q),
        .wdata_i   (wdata_q),
        .rd_lo_i   (rd_lo_q),
        .rd_hi_i   (rd_hi_q),
        .mask_o    (mask),
        .mis_o     (mis),
        .illegal_o (illegal),
        .wd_lo_o   (wd_lo),
        .wd_hi_o   (wd_hi),
        .ld_o      (ld)
    );
    assign bad = illegal | (mis & !ALLOW_MISALIGNED);
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = req.req_valid ? (bad ? RESP : BEAT1) : IDLE;
            BEAT1:   state_d = mem.mem_ready ? (|mask[2*NB-1:NB] ? BEAT2 : RESP) : BEAT1;
            BEAT2:   state_d = mem.mem_ready ? RESP : BEAT2;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= '0;
            off_q    <= '0;
            base_q   <= '0;
            wdata_q  <= '0;
            rd_lo_q  <= '0;
            rd_hi_q  <= '0;
        end else begin
            state_q <= state_d;
            if (idle && req.req_valid) begin
                write_q  <= req.req_write;
                signed_q <= req.req_signed;
                err_q    <= bad;
                size_q   <= req.req_size;
                off_q    <= req.req_addr[OW-1:0];
                base_q   <= req.req_addr & ~XLEN'(NB - 1);
                wdata_q  <= req.req_wdata;
                rd_lo_q  <= '0;
                rd_hi_q  <= '0;
            end
            if (b1 && mem.mem_ready) rd_lo_q <= mem.mem_rdata;
            if (b2 && mem.mem_ready) rd_hi_q <= mem.mem_rdata;
        end
    end
    assign req.req_ready  = idle;
    assign req.resp_valid = state_q == RESP;
    assign req.resp_err   = req.resp_valid & err_q;
    assign req.resp_rdata = (req.resp_valid && !write_q && !err_q) ? ld : '0;
    assign mem.mem_valid  = b1 | b2;
    assign mem.mem_we     = mem.mem_valid & write_q;
    assign mem.mem_addr   = b1 ? base_q : b2 ? base_q + XLEN'(NB) : '0;
    assign mem.mem_be     = b1 ? mask[NB-1:0] : b2 ? mask[2*NB-1:NB] : '0;
    assign mem.mem_wdata  = b1 ? wd_lo : b2 ? wd_hi : '0;
endmodule

// File: tb/tb_lsu_datapath_ctrl.sv
// tb_lsu_datapath_ctrl: directed checks of aligned, split, rejected, stalled and reset-aborted accesses.
module tb_lsu_datapath_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    lsu_req_if #(.XLEN(32)) ra ();
    lsu_mem_if #(.XLEN(32)) ma ();
    lsu_req_if #(.XLEN(32)) rb ();
    lsu_mem_if #(.XLEN(32)) mb ();
    lsu_datapath_ctrl #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) u_a (.clk(clk), .rst(rst), .req(ra), .mem(ma));
    lsu_datapath_ctrl #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) u_b (.clk(clk), .rst(rst), .req(rb), .mem(mb));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req_a(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        ra.req_valid  = 1'b1;
        ra.req_write  = w;
        ra.req_size   = sz;
        ra.req_signed = sg;
        ra.req_addr   = a;
        ra.req_wdata  = wd;
        chk("req_ready_accept", 32'(ra.req_ready), 32'd1);
        @(negedge clk);
        ra.req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ra.req_valid = 0; ra.req_write = 0; ra.req_size = 0; ra.req_signed = 0;
        ra.req_addr = 0; ra.req_wdata = 0;
        rb.req_valid = 0; rb.req_write = 0; rb.req_size = 0; rb.req_signed = 0;
        rb.req_addr = 0; rb.req_wdata = 0;
        ma.mem_ready = 1; ma.mem_rdata = 0;
        mb.mem_ready = 1; mb.mem_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(ra.req_ready), 1);
        chk("rst_resp_valid", 32'(ra.resp_valid), 0);
        chk("rst_resp_rdata", ra.resp_rdata, 0);
        chk("rst_resp_err", 32'(ra.resp_err), 0);
        chk("rst_mem_valid", 32'(ma.mem_valid), 0);
        chk("rst_mem_addr", ma.mem_addr, 0);
        chk("rst_mem_we", 32'(ma.mem_we), 0);
        chk("rst_mem_be", 32'(ma.mem_be), 0);
        chk("rst_mem_wdata", ma.mem_wdata, 0);
        rst = 1'b0;
        @(negedge clk);

        req_a(0, 2'b00, 0, 32'h100, 0);
        ma.mem_rdata = 32'hDEADBEEF;
        chk("lw_mem_valid", 32'(ma.mem_valid), 1);
        chk("lw_mem_addr", ma.mem_addr, 32'h100);
        chk("lw_mem_be", 32'(ma.mem_be), 32'hF);
        chk("lw_mem_we", 32'(ma.mem_we), 0);
        chk("lw_req_ready_busy", 32'(ra.req_ready), 0);
        chk("lw_no_early_resp", 32'(ra.resp_valid), 0);
        @(negedge clk);
        chk("lw_resp_valid", 32'(ra.resp_valid), 1);
        chk("lw_resp_rdata", ra.resp_rdata, 32'hDEADBEEF);
        chk("lw_resp_err", 32'(ra.resp_err), 0);
        chk("lw_resp_ready", 32'(ra.req_ready), 0);
        chk("lw_resp_mem_idle", 32'(ma.mem_valid), 0);
        @(negedge clk);
        chk("lw_pulse_end", 32'(ra.resp_valid), 0);

        req_a(0, 2'b10, 1, 32'h103, 0);
        ma.mem_rdata = 32'h80FFFFFF;
        chk("lb_mem_be", 32'(ma.mem_be), 32'h8);
        chk("lb_mem_addr", ma.mem_addr, 32'h100);
        @(negedge clk);
        chk("lb_rdata", ra.resp_rdata, 32'hFFFFFF80);
        @(negedge clk);
        req_a(0, 2'b10, 0, 32'h103, 0);
        @(negedge clk);
        chk("lbu_rdata", ra.resp_rdata, 32'h00000080);
        @(negedge clk);

        req_a(0, 2'b01, 1, 32'h102, 0);
        ma.mem_rdata = 32'h80011234;
        chk("lh_mem_be", 32'(ma.mem_be), 32'hC);
        @(negedge clk);
        chk("lh_rdata", ra.resp_rdata, 32'hFFFF8001);
        @(negedge clk);

        req_a(1, 2'b01, 0, 32'h102, 32'h1234ABCD);
        chk("sh_mem_be", 32'(ma.mem_be), 32'hC);
        chk("sh_mem_wdata", ma.mem_wdata, 32'hABCD0000);
        chk("sh_mem_we", 32'(ma.mem_we), 1);
        chk("sh_mem_addr", ma.mem_addr, 32'h100);
        @(negedge clk);
        chk("sh_resp_valid", 32'(ra.resp_valid), 1);
        chk("sh_resp_rdata", ra.resp_rdata, 0);
        @(negedge clk);

        req_a(0, 2'b00, 0, 32'h0FE, 0);
        ma.mem_rdata = 32'h55660000;
        chk("mlw_b1_addr", ma.mem_addr, 32'h0FC);
        chk("mlw_b1_be", 32'(ma.mem_be), 32'hC);
        @(negedge clk);
        ma.mem_rdata = 32'h00007788;
        chk("mlw_b2_valid", 32'(ma.mem_valid), 1);
        chk("mlw_b2_addr", ma.mem_addr, 32'h100);
        chk("mlw_b2_be", 32'(ma.mem_be), 32'h3);
        chk("mlw_b2_no_resp", 32'(ra.resp_valid), 0);
        @(negedge clk);
        chk("mlw_resp_valid", 32'(ra.resp_valid), 1);
        chk("mlw_resp_rdata", ra.resp_rdata, 32'h77885566);
        chk("mlw_resp_err", 32'(ra.resp_err), 0);
        @(negedge clk);

        req_a(1, 2'b00, 0, 32'h0FE, 32'hAABBCCDD);
        chk("msw_b1_wdata", ma.mem_wdata, 32'hCCDD0000);
        chk("msw_b1_we", 32'(ma.mem_we), 1);
        @(negedge clk);
        chk("msw_b2_wdata", ma.mem_wdata, 32'h0000AABB);
        chk("msw_b2_be", 32'(ma.mem_be), 32'h3);
        @(negedge clk);
        chk("msw_resp_valid", 32'(ra.resp_valid), 1);
        @(negedge clk);

        rb.req_valid = 1; rb.req_write = 0; rb.req_size = 2'b00; rb.req_addr = 32'h0FE;
        chk("rej_req_ready", 32'(rb.req_ready), 1);
        @(negedge clk);
        rb.req_valid = 0;
        chk("rej_mem_valid", 32'(mb.mem_valid), 0);
        chk("rej_resp_valid", 32'(rb.resp_valid), 1);
        chk("rej_resp_err", 32'(rb.resp_err), 1);
        chk("rej_resp_rdata", rb.resp_rdata, 0);
        @(negedge clk);
        chk("rej_pulse_end", 32'(rb.resp_valid), 0);

        req_a(0, 2'b11, 0, 32'h100, 0);
        chk("sz11_mem_valid", 32'(ma.mem_valid), 0);
        chk("sz11_resp_valid", 32'(ra.resp_valid), 1);
        chk("sz11_resp_err", 32'(ra.resp_err), 1);
        @(negedge clk);

        ma.mem_ready = 0;
        req_a(0, 2'b00, 0, 32'h200, 0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_mem_valid", 32'(ma.mem_valid), 1);
            chk("stall_mem_addr", ma.mem_addr, 32'h200);
            chk("stall_mem_be", 32'(ma.mem_be), 32'hF);
            chk("stall_req_ready", 32'(ra.req_ready), 0);
            chk("stall_no_resp", 32'(ra.resp_valid), 0);
            @(negedge clk);
        end
        ma.mem_ready = 1;
        ma.mem_rdata = 32'hCAFEF00D;
        chk("stall_still_valid", 32'(ma.mem_valid), 1);
        @(negedge clk);
        chk("stall_resp_rdata", ra.resp_rdata, 32'hCAFEF00D);
        @(negedge clk);

        req_a(0, 2'b00, 0, 32'h0FE, 0);
        @(negedge clk);
        chk("rstb2_addr", ma.mem_addr, 32'h100);
        rst = 1'b1;
        @(negedge clk);
        chk("rstb2_mem_valid", 32'(ma.mem_valid), 0);
        chk("rstb2_resp_valid", 32'(ra.resp_valid), 0);
        chk("rstb2_req_ready", 32'(ra.req_ready), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("rstb2_no_late_resp", 32'(ra.resp_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
